// File: rtl/nios_cpu_onchip_mem_stream_reader.sv
// nios_cpu_onchip_mem_stream_reader
// Reads a run of consecutive words from an on-chip RAM slave (one-cycle read
// latency) and streams them out on an Avalon-ST source with sop/eop framing.
// A small FIFO absorbs sink backpressure. Reads are only issued when the FIFO
// is guaranteed to have room for the returning word.
// Optional feature macro: NIOS_CPU_MEM_READER_CHECKSUM_EN adds a checksum
// output holding the modulo-2^32 sum of the words delivered for the current
// command.
module nios_cpu_onchip_mem_stream_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 4849
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [12:0] cmd_addr,
  input  logic [12:0] cmd_len,
  output logic [12:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,
  output logic        src_valid,
  input  logic        src_ready,
  output logic [31:0] src_data,
  output logic        src_sop,
  output logic        src_eop,
  output logic        busy,
  output logic        err
`ifdef NIOS_CPU_MEM_READER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [13:0]   MEM_LIMIT = 14'(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state_r, state_next;
  logic          cmd_ready_r, busy_r, err_r, clken_r;
  logic          inflight_r, first_r;
  logic [12:0]   addr_r, remaining_r, out_left_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] fifo_count_r;
  logic [31:0]   fifo_mem [FIFO_DEPTH];

  logic          accept_s, cmd_bad_s, cmd_ok_s;
  logic          room_s, rd_issue_s, push_s, pop_s, fifo_nonempty_s;
  logic [13:0]   cmd_end_s;
  logic [CW-1:0] occupancy_s;

  // The end address is formed in 14 bits so that addr + len cannot wrap.
  assign accept_s        = cmd_valid & cmd_ready_r;
  assign cmd_end_s       = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign cmd_bad_s       = (cmd_len == 13'd0) || (cmd_end_s > MEM_LIMIT);
  assign cmd_ok_s        = accept_s & ~cmd_bad_s & (state_r == ST_IDLE);

  // A read is only issued if the word already in flight still leaves a slot.
  assign occupancy_s     = fifo_count_r + {{AW{1'b0}}, inflight_r};
  assign room_s          = (occupancy_s < DEPTH_C);
  assign rd_issue_s      = (state_r == ST_READ) && (remaining_r != 13'd0) && room_s;
  assign push_s          = inflight_r;
  assign fifo_nonempty_s = (fifo_count_r != {CW{1'b0}});
  assign pop_s           = fifo_nonempty_s & src_ready;

  assign cmd_ready       = cmd_ready_r;
  assign mem_address     = addr_r;
  assign mem_chipselect  = rd_issue_s;
  assign mem_write       = 1'b0;
  assign mem_byteenable  = 4'hF;
  assign mem_clken       = clken_r;
  assign src_valid       = fifo_nonempty_s;
  assign src_data        = fifo_mem[rd_ptr_r];
  assign src_sop         = fifo_nonempty_s & first_r;
  assign src_eop         = fifo_nonempty_s & (out_left_r == 13'd1);
  assign busy            = busy_r;
  assign err             = err_r;

  // Next-state logic for the IDLE / READ / DRAIN controller.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_ok_s) state_next = ST_READ;
        else          state_next = ST_IDLE;
      end
      ST_READ: begin
        if (rd_issue_s && (remaining_r == 13'd1)) state_next = ST_DRAIN;
        else                                      state_next = ST_READ;
      end
      ST_DRAIN: begin
        if (!inflight_r && (!fifo_nonempty_s ||
            ((fifo_count_r == CW'(1)) && pop_s))) state_next = ST_IDLE;
        else                                      state_next = ST_DRAIN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and the status flags derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      clken_r     <= 1'b0;
    end else begin
      state_r     <= state_next;
      cmd_ready_r <= (state_next == ST_IDLE);
      busy_r      <= (state_next != ST_IDLE);
      err_r       <= accept_s & cmd_bad_s;
      clken_r     <= 1'b1;
    end
  end

  // Read address / remaining-count tracking; address holds on the last word
  // so it never points past the end of memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r      <= 13'd0;
      remaining_r <= 13'd0;
      inflight_r  <= 1'b0;
    end else begin
      inflight_r <= rd_issue_s;
      if (cmd_ok_s) begin
        addr_r      <= cmd_addr;
        remaining_r <= cmd_len;
      end else if (rd_issue_s) begin
        addr_r      <= (remaining_r != 13'd1) ? (addr_r + 13'd1) : addr_r;
        remaining_r <= remaining_r - 13'd1;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      fifo_count_r <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // FIFO storage: returning RAM data is captured the cycle after the read.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem[wr_ptr_r] <= mem_readdata;
  end

  // Output framing: first-word flag and words left to deliver for eop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_r    <= 1'b0;
      out_left_r <= 13'd0;
    end else if (cmd_ok_s) begin
      first_r    <= 1'b1;
      out_left_r <= cmd_len;
    end else if (pop_s) begin
      first_r    <= 1'b0;
      out_left_r <= out_left_r - 13'd1;
    end
  end

`ifdef NIOS_CPU_MEM_READER_CHECKSUM_EN
  logic [31:0] checksum_r;
  assign checksum = checksum_r;

  // Running sum of delivered words, restarted by every accepted command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_r <= 32'd0;
    end else if (accept_s) begin
      checksum_r <= 32'd0;
    end else if (pop_s) begin
      checksum_r <= checksum_r + src_data;
    end
  end
`endif

endmodule

// File: tb/tb_nios_cpu_onchip_mem_stream_reader.sv
// Testbench for nios_cpu_onchip_mem_stream_reader. The RAM model returns the
// word address as data one cycle after chipselect. Expected stream words are
// queued when a command is driven and compared as the source delivers them.
module tb_nios_cpu_onchip_mem_stream_reader;

  localparam int DEPTH = 4;
  localparam int WORDS = 4849;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [12:0] cmd_addr;
  logic [12:0] cmd_len;
  logic [12:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] src_data;
  logic        src_sop;
  logic        src_eop;
  logic        busy;
  logic        err;
`ifdef NIOS_CPU_MEM_READER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_q [$];

  nios_cpu_onchip_mem_stream_reader #(
    .FIFO_DEPTH(DEPTH),
    .MEM_WORDS (WORDS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_byteenable(mem_byteenable),
    .mem_clken     (mem_clken),
    .mem_readdata  (mem_readdata),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_data      (src_data),
    .src_sop       (src_sop),
    .src_eop       (src_eop),
    .busy          (busy),
    .err           (err)
`ifdef NIOS_CPU_MEM_READER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: word n holds n, data appears one cycle after chipselect.
  always @(posedge clk) begin
    mem_readdata <= mem_chipselect ? {19'd0, mem_address} : 32'hDEAD_BEEF;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_words(input int a, input int l);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({(i == 0), (i == l - 1), 32'(a + i)});
    end
  endtask

  // Present a command at a negedge; returns on the negedge after acceptance.
  task automatic drive_cmd(input logic [12:0] a, input logic [12:0] l);
    int w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept: cmd_ready=%0b, required 1 within 20 cycles", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 13'd0; cmd_len = 13'd0; src_ready = 1'b0;
    repeat (3) @(negedge clk);
    obs = {cmd_ready, mem_chipselect, mem_clken, mem_address, src_valid, src_sop, src_eop, busy, err};
    n_cmp++;
    if (obs !== 21'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h, required %h", obs, 21'd0);
    end
    n_cmp++;
    if ({mem_write, mem_byteenable} !== 5'b0_1111) begin
      n_err++; $display("FAIL tie_offs: got %b, required %b", {mem_write, mem_byteenable}, 5'b0_1111);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, mem_clken, busy, src_valid} !== 4'b1100) begin
      n_err++; $display("FAIL after_reset: got %b, required %b", {cmd_ready, mem_clken, busy, src_valid}, 4'b1100);
    end
`ifdef NIOS_CPU_MEM_READER_CHECKSUM_EN
    n_cmp++;
    if (checksum !== 32'd0) begin
      n_err++; $display("FAIL reset_checksum: got %h, required 0", checksum);
    end
`endif
  endtask

  task automatic test_basic();
    int lat, bubbles;
    logic [33:0] got, want;
    src_ready = 1'b1;
    push_words(16, 4);
    drive_cmd(13'h010, 13'd4);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL basic_busy_set: got %0b, required 1", busy);
    end
    lat = 0;
    while (!src_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 2) begin
      n_err++; $display("FAIL basic_latency: got %0d cycles, required 2", lat);
    end
    bubbles = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (src_valid) begin
        got = {src_sop, src_eop, src_data};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_err++; $display("FAIL basic_word: got %h, required %h", got, want);
        end
      end else begin
        bubbles++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({bubbles, exp_q.size()} !== {32'd0, 32'd0}) begin
      n_err++; $display("FAIL basic_stream: bubbles=%0d left=%0d, required 0 and 0", bubbles, exp_q.size());
    end
    n_cmp++;
    if ({busy, cmd_ready, src_valid} !== 3'b010) begin
      n_err++; $display("FAIL basic_done: busy/ready/valid got %b, required 010", {busy, cmd_ready, src_valid});
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int stall_reads, total_reads;
    logic seen, held_ok;
    logic [31:0] held;
    logic [33:0] got, want;
    src_ready = 1'b0;
    push_words(0, 8);
    drive_cmd(13'd0, 13'd8);
    stall_reads = 0; seen = 1'b0; held_ok = 1'b1; held = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      stall_reads += int'(mem_chipselect);
      if (src_valid && !seen) begin
        held = src_data; seen = 1'b1;
      end else if (seen && (!src_valid || src_data !== held)) begin
        held_ok = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (stall_reads !== DEPTH) begin
      n_err++; $display("FAIL bp_stall_reads: got %0d, required %0d", stall_reads, DEPTH);
    end
    n_cmp++;
    if ({seen, held_ok, held} !== {1'b1, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL bp_hold: seen=%0b stable=%0b data=%h, required 1 1 0", seen, held_ok, held);
    end
    src_ready = 1'b1;
    total_reads = stall_reads;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      total_reads += int'(mem_chipselect);
      if (src_valid) begin
        got = {src_sop, src_eop, src_data};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_err++; $display("FAIL bp_word: got %h, required %h", got, want);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({total_reads, exp_q.size(), 31'd0, busy} !== {32'd8, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL bp_totals: reads=%0d left=%0d busy=%0b, required 8 0 0", total_reads, exp_q.size(), busy);
    end
    exp_q.delete();
  endtask

  task automatic test_bounds();
    int cs, errs;
    int ca [2];
    int cl [2];
    logic [33:0] got, want;
    ca = '{4845, 4848};
    cl = '{4, 1};
    src_ready = 1'b1;
    drive_cmd(13'd4845, 13'd5);
    n_cmp++;
    if ({err, busy, cmd_ready} !== 3'b101) begin
      n_err++; $display("FAIL bound_reject: err/busy/ready got %b, required 101", {err, busy, cmd_ready});
    end
    cs = int'(mem_chipselect); errs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cs += int'(mem_chipselect);
      errs += int'(err);
    end
    n_cmp++;
    if ({cs, errs} !== {32'd0, 32'd0}) begin
      n_err++; $display("FAIL bound_no_access: chipselects=%0d extra_err=%0d, required 0 0", cs, errs);
    end
    for (int k = 0; k < 2; k++) begin
      push_words(ca[k], cl[k]);
      drive_cmd(13'(ca[k]), 13'(cl[k]));
      for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
        if (src_valid) begin
          got = {src_sop, src_eop, src_data};
          want = exp_q.pop_front();
          n_cmp++;
          if (got !== want) begin
            n_err++; $display("FAIL bound_word: got %h, required %h", got, want);
          end
        end
        @(negedge clk);
      end
      n_cmp++;
      if ({exp_q.size(), 31'd0, busy} !== {32'd0, 32'd0}) begin
        n_err++; $display("FAIL bound_stream: left=%0d busy=%0b, required 0 0", exp_q.size(), busy);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_zero_len();
    drive_cmd(13'h020, 13'd0);
    n_cmp++;
    if ({err, busy, cmd_ready} !== 3'b101) begin
      n_err++; $display("FAIL zero_len_err: err/busy/ready got %b, required 101", {err, busy, cmd_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({err, busy, cmd_ready, mem_chipselect, src_valid} !== 5'b00100) begin
      n_err++; $display("FAIL zero_len_after: got %b, required 00100", {err, busy, cmd_ready, mem_chipselect, src_valid});
    end
  endtask

  task automatic test_reset_mid();
    int delivered, stray;
    logic [20:0] obs;
    logic [33:0] got, want;
    src_ready = 1'b1;
    push_words(256, 16);
    drive_cmd(13'd256, 13'd16);
    delivered = 0;
    for (int c = 0; c < 40 && delivered < 5; c++) begin
      if (src_valid) begin
        got = {src_sop, src_eop, src_data};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_err++; $display("FAIL mid_word: got %h, required %h", got, want);
        end
        delivered++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (delivered !== 5) begin
      n_err++; $display("FAIL mid_delivered: got %0d, required 5", delivered);
    end
    reset_n = 1'b0;
    #1;
    obs = {cmd_ready, mem_chipselect, mem_clken, mem_address, src_valid, src_sop, src_eop, busy, err};
    n_cmp++;
    if (obs !== 21'd0) begin
      n_err++; $display("FAIL mid_async_reset: got %h, required %h", obs, 21'd0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      stray += int'(src_valid | mem_chipselect | busy);
    end
    n_cmp++;
    if ({stray, 31'd0, cmd_ready} !== {32'd0, 32'd1}) begin
      n_err++; $display("FAIL mid_after_release: stray=%0d ready=%0b, required 0 1", stray, cmd_ready);
    end
  endtask

  task automatic test_random();
    int len, addr;
    logic [33:0] got, want;
    for (int k = 0; k < 4; k++) begin
      len  = $urandom_range(1, 12);
      addr = $urandom_range(0, WORDS - len);
      push_words(addr, len);
      drive_cmd(13'(addr), 13'(len));
      for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
        src_ready = ($urandom_range(0, 3) != 0);
        if (src_valid && src_ready) begin
          got = {src_sop, src_eop, src_data};
          want = exp_q.pop_front();
          n_cmp++;
          if (got !== want) begin
            n_err++; $display("FAIL rand_word: got %h, required %h", got, want);
          end
        end
        @(negedge clk);
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin
        n_err++; $display("FAIL rand_stream: left=%0d, required 0", exp_q.size());
      end
      exp_q.delete();
    end
    src_ready = 1'b1;
  endtask

`ifdef NIOS_CPU_MEM_READER_CHECKSUM_EN
  task automatic test_checksum();
    src_ready = 1'b1;
    drive_cmd(13'd1, 13'd3);
    for (int c = 0; c < 30 && busy; c++) @(negedge clk);
    n_cmp++;
    if (checksum !== 32'd6) begin
      n_err++; $display("FAIL checksum_sum: got %0d, required 6", checksum);
    end
    drive_cmd(13'd5, 13'd1);
    n_cmp++;
    if (checksum !== 32'd0) begin
      n_err++; $display("FAIL checksum_clear: got %0d, required 0", checksum);
    end
    for (int c = 0; c < 30 && busy; c++) @(negedge clk);
    n_cmp++;
    if (checksum !== 32'd5) begin
      n_err++; $display("FAIL checksum_single: got %0d, required 5", checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bounds();
    test_zero_len();
    test_reset_mid();
    test_random();
`ifdef NIOS_CPU_MEM_READER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nios_cpu_onchip_mem_stream_reader.md
NIOS_CPU_ONCHIP_MEM_STREAM_READER -- requirements
Module: nios_cpu_onchip_mem_stream_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of 2, 2..16).
REQ-002 SHALL have parameter MEM_WORDS, default 4849, highest legal word address + 1.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_addr  in  13  start word address.
REQ-008 cmd_len  in  13  word count.
REQ-009 mem_address  out  13  word address to on-chip RAM slave.
REQ-010 mem_chipselect  out  1  read strobe; mem_write tied 0, mem_byteenable tied 4'hF.
REQ-011 mem_clken  out  1  constant 1 out of reset.
REQ-012 mem_readdata  in  32  RAM data, valid exactly 1 cycle after mem_chipselect.
REQ-013 src_valid / src_ready  out / in  1 / 1  Avalon-ST source handshake.
REQ-014 src_data  out  32  stream word; src_sop / src_eop  out  1 each  first / last word of command.
REQ-015 busy  out  1  high from command accept until last word transferred.
REQ-016 err  out  1  one-cycle pulse on rejected command.

Function
REQ-017 States IDLE, READ, DRAIN; cmd_ready = 1 only in IDLE.
REQ-018 IDLE: accepted command with cmd_len == 0 or cmd_addr + cmd_len > MEM_WORDS (14-bit sum) SHALL be rejected: err pulses next cycle, state stays IDLE, no memory access.
REQ-019 IDLE: legal command loads addr and remaining count, sets busy next cycle, goes READ.
REQ-020 READ: mem_chipselect asserted in a cycle iff remaining > 0 and (fifo_count + inflight) < FIFO_DEPTH; addr increments, remaining decrements per issued read.
REQ-021 Each read's mem_readdata SHALL be written into FIFO the following cycle; inflight is 0 or 1.
REQ-022 READ -> DRAIN the cycle after the last read issues; DRAIN -> IDLE when FIFO empty, inflight 0 and last word handshaken; busy drops same edge.
REQ-023 src_valid = FIFO non-empty; word leaves on src_valid & src_ready; src_data stable while src_valid & ~src_ready.
REQ-024 src_sop on first word of command, src_eop on word index cmd_len-1; both on same word when cmd_len == 1.
REQ-025 Simultaneous FIFO push and pop SHALL leave occupancy unchanged; FIFO never overflows, never underflows.
REQ-026 Zero bubble: with src_ready held 1, throughput SHALL be one word per cycle after 2-cycle first-word latency (accept -> first src_valid).
REQ-027 Address SHALL never exceed MEM_WORDS-1; no wrap-around is generated.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, cmd_ready 0 during reset then 1, mem_chipselect 0, mem_clken 0, mem_address 0, src_valid 0, src_sop 0, src_eop 0, busy 0, err 0, FIFO empty, inflight 0.
REQ-029 Reset mid-command SHALL discard all buffered and in-flight data; no word delivered after deassertion without a new command.

Configuration
REQ-030 Macro NIOS_CPU_MEM_READER_CHECKSUM_EN: when defined, output checksum[31:0] SHALL hold modulo-2^32 sum of all words delivered in current command, cleared on command accept and reset, final on cycle after eop handshake.
REQ-031 Without the macro, checksum port and adder SHALL be absent; all other behaviour identical.

Verification
REQ-032 RAM preloaded addr n = n; cmd addr 0x010 len 4, src_ready=1 -> data 0x10..0x13, sop on 0x10, eop on 0x13, first valid 2 cycles after accept, busy low after.
REQ-033 cmd addr 0x000 len 8, src_ready low 10 cycles then 1 -> at most FIFO_DEPTH reads issued while stalled, 8 words in order, none lost or duplicated.
REQ-034 cmd addr 4845 len 5 -> err pulse, no mem_chipselect; cmd addr 4848 len 1 -> one word 4848, sop and eop together.
REQ-035 cmd len 0 -> err pulse, busy stays 0, cmd_ready stays 1.
REQ-036 reset_n low during READ of len 16 after 5 words -> outputs per REQ-028 asynchronously; no src_valid after release until new command.
REQ-037 Macro defined, cmd addr 1 len 3 -> checksum = 6 after eop; new command clears to 0.
